conv_window_mac: RTL and testbench
==================================

# conv_window_mac

Streaming, parametrised K×K convolution multiply-accumulate engine for the object-detection datapath. It holds a loadable kernel of K·K weights and accepts one pixel tap per cycle over a valid/ready handshake. It returns the dot product of window and kernel as a single result word, with selectable saturation and an overflow flag. It generalises the fixed 3×3, 8-bit, combinational elementwise-multiply-and-sum stage into a clocked, back-pressurable, arbitrary-size block.

## Interface
- DATA_W, 8, width of pixel and weight (unsigned)
- K, 3, kernel side; N = K·K taps per window (K ≥ 1)
- OUT_W, 8, result width
- SAT, 1, 1 = clamp result to 2^OUT_W−1; 0 = keep low OUT_W bits (wrap)
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- w_valid  in  1  weight beat offered
- w_data  in  DATA_W  weight value, row-major order
- w_ready  out  1  weight beat accepted when w_valid & w_ready
- in_valid  in  1  pixel tap offered
- in_data  in  DATA_W  pixel value, row-major order matching weights
- in_ready  out  1  tap accepted when in_valid & in_ready
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_sum  out  OUT_W  window result
- out_ovf  out  1  full-precision sum exceeded 2^OUT_W−1
- k_loaded  out  1  complete kernel present

## Operation
- Internal accumulator width ACC_W = 2·DATA_W + ceil(log2(N)); it never overflows internally.
- Weight bank: N registers, cleared by reset. Tap counter and weight index run 0..N−1.
- IDLE: w_ready=1; in_ready = k_loaded & ~w_valid (weight load has priority).
  - Accepted weight beat → write weight[0], widx=1, go LOAD. If N=1, set k_loaded and stay IDLE.
  - Accepted tap → acc = in_data·weight[0], tap=1, go ACC. If N=1, go HOLD.
- LOAD: w_ready=1, in_ready=0, k_loaded=0 (cleared on entry).
  - Each beat writes weight[widx].
  - The beat at widx=N−1 sets k_loaded=1 and goes IDLE.
  - Cycles without w_valid hold state.
- ACC: in_ready=1, w_ready=0.
  - Each accepted tap adds in_data·weight[tap].
  - The tap at index N−1 registers the result and goes HOLD.
  - in_valid=0 cycles are bubbles and do not advance tap.
- HOLD: out_valid=1, in_ready=0, w_ready=0. out_sum/out_ovf are stable until out_ready=1, then go IDLE and drop out_valid the next cycle.
- Result: out_ovf = (acc > 2^OUT_W−1).
  - SAT=1: out_sum = out_ovf ? all-ones : acc[OUT_W−1:0].
  - SAT=0: out_sum = acc[OUT_W−1:0].
  - If ACC_W ≤ OUT_W, out_ovf is constant 0.
- Weights persist across windows; reloading from IDLE replaces the whole kernel.

## Timing
- Reset (asynchronous, any state):
  - State→IDLE; acc, tap, widx, weights, k_loaded, out_valid, out_sum, out_ovf → 0.
  - w_ready=1, in_ready=0.
  - A partial window or partial kernel load is discarded.
- Latency: out_valid rises on the edge that accepts tap N−1, i.e. the cycle after the last tap is presented.
- Throughput: best case one window per N+1 cycles (N taps + one HOLD cycle with out_ready=1).
- Kernel load: N cycles minimum; in_ready is 0 throughout.
- No combinational path from in_valid to in_ready or to outputs. in_ready depends on w_valid in IDLE only.
- out_sum/out_ovf change only on the HOLD-entry edge or on reset.

## Test plan
- Reset: assert rst mid-cycle → immediately out_valid=0, out_sum=0, out_ovf=0, k_loaded=0, w_ready=1, in_ready=0.
- Basic 3×3, SAT=1:
  - Stimulus: weights 5,5,5,2,2,2,1,1,1; taps with the same values; out_ready=1.
  - Response: out_sum=90, out_ovf=0; out_valid one cycle after the 9th tap.
- Overflow: weights and taps all 255.
  - SAT=1 → out_sum=255, out_ovf=1.
  - SAT=0 → out_sum=9, out_ovf=1 (585225 mod 256).
- Handshake stress with the basic-case values:
  - Random in_valid bubbles plus out_ready=0 for 5 cycles → result still 90; out_valid and out_sum held; in_ready=0 during HOLD.
  - w_valid and in_valid together in IDLE → weight accepted, tap not accepted.
- Reset mid-operation:
  - rst after 4 taps → state IDLE, k_loaded=0, and in_valid is refused.
  - Reload the kernel and run a full window → correct result.
- Parameter sweep: K=1 and K=5 with DATA_W=4, OUT_W=12.
  - K=1, weight 15, tap 15 → out_sum=225, out_ovf=0.
  - K=5, all weights and taps 15 → out_sum=4095, out_ovf=1 for SAT=1; out_sum=1529, out_ovf=1 for SAT=0 (5625 mod 4096).

Source files
------------

// File: rtl/conv_window_mac.sv
// conv_window_mac: streaming KxK kernel multiply-accumulate with valid/ready handshakes
module conv_window_mac #(
    parameter int DATA_W = 8,
    parameter int K      = 3,
    parameter int OUT_W  = 8,
    parameter int SAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_valid,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_ready,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              k_loaded
);
    localparam int N     = K * K;
    localparam int ACC_W = 2 * DATA_W + $clog2(N);
    localparam int IDX_W = N > 1 ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, ACC, HOLD} state_t;

    state_t             state_q;
    logic [DATA_W-1:0]  w_q [N];
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]   tap_q, widx_q, sel;
    logic [ACC_W+OUT_W-1:0] sum_x;
    logic [OUT_W-1:0]   out_sum_q, res;
    logic               out_ovf_q, out_valid_q, k_loaded_q, ovf, last;

    assign w_ready   = state_q == IDLE || state_q == LOAD;
    assign in_ready  = state_q == ACC || (state_q == IDLE && k_loaded_q && !w_valid);
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;
    assign k_loaded  = k_loaded_q;

    // Running dot product; a tap accepted in IDLE starts a fresh window from zero
    always_comb begin
        sel   = state_q == IDLE ? '0 : tap_q;
        acc_d = (state_q == IDLE ? '0 : acc_q) + ACC_W'(in_data) * ACC_W'(w_q[sel]);
        sum_x = (ACC_W+OUT_W)'(acc_d);
        ovf   = (sum_x >> OUT_W) != '0;
        res   = (SAT != 0 && ovf) ? '1 : sum_x[OUT_W-1:0];
        last  = state_q == IDLE ? (N == 1) : tap_q == IDX_W'(N-1);
    end

    // Control FSM with kernel bank, accumulator and registered result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            tap_q       <= '0;
            widx_q      <= '0;
            for (int i = 0; i < N; i++) w_q[i] <= '0;
            k_loaded_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                LOAD: if (w_valid) begin
                    w_q[widx_q] <= w_data;
                    if (widx_q == IDX_W'(N-1)) begin
                        k_loaded_q <= 1'b1;
                        widx_q     <= '0;
                        state_q    <= IDLE;
                    end else begin
                        widx_q <= widx_q + IDX_W'(1);
                    end
                end
                HOLD: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: if (state_q == IDLE && w_valid) begin
                    w_q[0] <= w_data;
                    if (N == 1) begin
                        k_loaded_q <= 1'b1;
                    end else begin
                        k_loaded_q <= 1'b0;
                        widx_q     <= IDX_W'(1);
                        state_q    <= LOAD;
                    end
                end else if (in_valid && in_ready) begin
                    if (last) begin
                        out_sum_q   <= res;
                        out_ovf_q   <= ovf;
                        out_valid_q <= 1'b1;
                        tap_q       <= '0;
                        state_q     <= HOLD;
                    end else begin
                        acc_q   <= acc_d;
                        tap_q   <= tap_q + IDX_W'(1);
                        state_q <= ACC;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv_window_mac.sv
// tb_conv_window_mac: directed-vector bench for conv_window_mac across several parameter sets
module tb_conv_window_mac;
    logic clk = 0, rst = 0;
    logic w_valid = 0, in_valid = 0, out_ready = 1;
    logic [7:0] w_data = 0, in_data = 0;
    logic [1:0] grp = 0;
    logic [7:0] wv [25];
    logic [7:0] tv [25];
    int vecs = 0, errs = 0;

    always #5 clk = ~clk;

    logic wr_a1, ir_a1, ov_a1, ovf_a1, kl_a1;
    logic wr_a0, ir_a0, ov_a0, ovf_a0, kl_a0;
    logic wr_b, ir_b, ov_b, ovf_b, kl_b;
    logic wr_c1, ir_c1, ov_c1, ovf_c1, kl_c1;
    logic wr_c0, ir_c0, ov_c0, ovf_c0, kl_c0;
    logic [7:0] sum_a1, sum_a0;
    logic [11:0] sum_b, sum_c1, sum_c0;
    logic ir;

    assign ir = grp == 2'd0 ? ir_a1 : grp == 2'd1 ? ir_b : ir_c1;

    conv_window_mac #(.DATA_W(8), .K(3), .OUT_W(8), .SAT(1)) u_a1 (
        .clk(clk), .rst(rst), .w_valid(w_valid && grp == 2'd0), .w_data(w_data), .w_ready(wr_a1),
        .in_valid(in_valid && grp == 2'd0), .in_data(in_data), .in_ready(ir_a1),
        .out_valid(ov_a1), .out_ready(out_ready), .out_sum(sum_a1), .out_ovf(ovf_a1), .k_loaded(kl_a1));
    conv_window_mac #(.DATA_W(8), .K(3), .OUT_W(8), .SAT(0)) u_a0 (
        .clk(clk), .rst(rst), .w_valid(w_valid && grp == 2'd0), .w_data(w_data), .w_ready(wr_a0),
        .in_valid(in_valid && grp == 2'd0), .in_data(in_data), .in_ready(ir_a0),
        .out_valid(ov_a0), .out_ready(out_ready), .out_sum(sum_a0), .out_ovf(ovf_a0), .k_loaded(kl_a0));
    conv_window_mac #(.DATA_W(4), .K(1), .OUT_W(12), .SAT(1)) u_b (
        .clk(clk), .rst(rst), .w_valid(w_valid && grp == 2'd1), .w_data(w_data[3:0]), .w_ready(wr_b),
        .in_valid(in_valid && grp == 2'd1), .in_data(in_data[3:0]), .in_ready(ir_b),
        .out_valid(ov_b), .out_ready(out_ready), .out_sum(sum_b), .out_ovf(ovf_b), .k_loaded(kl_b));
    conv_window_mac #(.DATA_W(4), .K(5), .OUT_W(12), .SAT(1)) u_c1 (
        .clk(clk), .rst(rst), .w_valid(w_valid && grp == 2'd2), .w_data(w_data[3:0]), .w_ready(wr_c1),
        .in_valid(in_valid && grp == 2'd2), .in_data(in_data[3:0]), .in_ready(ir_c1),
        .out_valid(ov_c1), .out_ready(out_ready), .out_sum(sum_c1), .out_ovf(ovf_c1), .k_loaded(kl_c1));
    conv_window_mac #(.DATA_W(4), .K(5), .OUT_W(12), .SAT(0)) u_c0 (
        .clk(clk), .rst(rst), .w_valid(w_valid && grp == 2'd2), .w_data(w_data[3:0]), .w_ready(wr_c0),
        .in_valid(in_valid && grp == 2'd2), .in_data(in_data[3:0]), .in_ready(ir_c0),
        .out_valid(ov_c0), .out_ready(out_ready), .out_sum(sum_c0), .out_ovf(ovf_c0), .k_loaded(kl_c0));

    // Stream n weights, one per cycle; starts and ends on a falling edge
    task automatic load_kernel(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            w_valid = 1;
            w_data = wv[i];
        end
        @(negedge clk);
        w_valid = 0;
    endtask

    // Offer one tap after gap idle cycles and hold it until accepted (bounded)
    task automatic send_tap(input logic [7:0] d, input int gap);
        int t;
        bit ok;
        t = 0;
        ok = 0;
        repeat (gap) @(negedge clk);
        in_valid = 1;
        in_data = d;
        while (!ok && t < 20) begin
            #1 ok = ir;
            @(negedge clk);
            t++;
        end
        in_valid = 0;
        if (!ok) begin
            vecs++; errs++;
            $display("FAIL tap_accept_timeout: grp %0d tap %0d not accepted in 20 cycles", grp, d);
        end
    endtask

    task automatic fill(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        for (int i = 0; i < 9; i++) begin
            wv[i] = i < 3 ? a : i < 6 ? b : c;
            tv[i] = wv[i];
        end
    endtask

    task automatic test_reset;
        #3 rst = 1;
        #1;
        vecs++; if (ov_a1 !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %0d expected 0", ov_a1); end
        vecs++; if (sum_a1 !== 8'd0) begin errs++; $display("FAIL reset_out_sum: got %0d expected 0", sum_a1); end
        vecs++; if (ovf_a1 !== 1'b0) begin errs++; $display("FAIL reset_out_ovf: got %0d expected 0", ovf_a1); end
        vecs++; if (kl_a1 !== 1'b0) begin errs++; $display("FAIL reset_k_loaded: got %0d expected 0", kl_a1); end
        vecs++; if (wr_a1 !== 1'b1) begin errs++; $display("FAIL reset_w_ready: got %0d expected 1", wr_a1); end
        vecs++; if (ir_a1 !== 1'b0) begin errs++; $display("FAIL reset_in_ready: got %0d expected 0", ir_a1); end
        vecs++; if (sum_c1 !== 12'd0) begin errs++; $display("FAIL reset_out_sum_k5: got %0d expected 0", sum_c1); end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_basic;
        grp = 0;
        out_ready = 1;
        fill(5, 2, 1);
        load_kernel(9);
        vecs++; if (kl_a1 !== 1'b1) begin errs++; $display("FAIL basic_k_loaded: got %0d expected 1", kl_a1); end
        for (int i = 0; i < 8; i++) send_tap(tv[i], 0);
        vecs++; if (ov_a1 !== 1'b0) begin errs++; $display("FAIL basic_early_valid: got %0d expected 0", ov_a1); end
        send_tap(tv[8], 0);
        vecs++; if (ov_a1 !== 1'b1) begin errs++; $display("FAIL basic_latency: got %0d expected 1", ov_a1); end
        vecs++; if (sum_a1 !== 8'd90) begin errs++; $display("FAIL basic_sum_sat: got %0d expected 90", sum_a1); end
        vecs++; if (ovf_a1 !== 1'b0) begin errs++; $display("FAIL basic_ovf_sat: got %0d expected 0", ovf_a1); end
        vecs++; if (sum_a0 !== 8'd90) begin errs++; $display("FAIL basic_sum_wrap: got %0d expected 90", sum_a0); end
        @(negedge clk);
        vecs++; if (ov_a1 !== 1'b0) begin errs++; $display("FAIL basic_valid_drop: got %0d expected 0", ov_a1); end
    endtask

    task automatic test_overflow;
        grp = 0;
        fill(255, 255, 255);
        load_kernel(9);
        for (int i = 0; i < 9; i++) send_tap(tv[i], 0);
        vecs++; if (sum_a1 !== 8'd255) begin errs++; $display("FAIL ovf_sum_sat: got %0d expected 255", sum_a1); end
        vecs++; if (ovf_a1 !== 1'b1) begin errs++; $display("FAIL ovf_flag_sat: got %0d expected 1", ovf_a1); end
        vecs++; if (sum_a0 !== 8'd9) begin errs++; $display("FAIL ovf_sum_wrap: got %0d expected 9", sum_a0); end
        vecs++; if (ovf_a0 !== 1'b1) begin errs++; $display("FAIL ovf_flag_wrap: got %0d expected 1", ovf_a0); end
        @(negedge clk);
    endtask

    task automatic test_handshake;
        grp = 0;
        fill(5, 2, 1);
        w_valid = 1;
        w_data = wv[0];
        in_valid = 1;
        in_data = 8'd99;
        #1;
        vecs++; if (ir_a1 !== 1'b0) begin errs++; $display("FAIL prio_in_ready: got %0d expected 0", ir_a1); end
        vecs++; if (wr_a1 !== 1'b1) begin errs++; $display("FAIL prio_w_ready: got %0d expected 1", wr_a1); end
        @(negedge clk);
        in_valid = 0;
        vecs++; if (kl_a1 !== 1'b0) begin errs++; $display("FAIL load_k_loaded_clear: got %0d expected 0", kl_a1); end
        for (int i = 1; i < 9; i++) begin
            w_data = wv[i];
            @(negedge clk);
        end
        w_valid = 0;
        vecs++; if (kl_a1 !== 1'b1) begin errs++; $display("FAIL reload_k_loaded: got %0d expected 1", kl_a1); end
        out_ready = 0;
        for (int i = 0; i < 9; i++) send_tap(tv[i], (i % 3 == 1) ? 2 : 0);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1;
            in_data = 8'd7;
            #1;
            vecs++; if (ov_a1 !== 1'b1) begin errs++; $display("FAIL hold_valid: cycle %0d got %0d expected 1", c, ov_a1); end
            vecs++; if (sum_a1 !== 8'd90) begin errs++; $display("FAIL hold_sum: cycle %0d got %0d expected 90", c, sum_a1); end
            vecs++; if (ir_a1 !== 1'b0) begin errs++; $display("FAIL hold_in_ready: cycle %0d got %0d expected 0", c, ir_a1); end
            @(negedge clk);
        end
        in_valid = 0;
        out_ready = 1;
        @(negedge clk);
        vecs++; if (ov_a1 !== 1'b0) begin errs++; $display("FAIL hold_release: got %0d expected 0", ov_a1); end
    endtask

    task automatic test_reset_mid;
        grp = 0;
        fill(5, 2, 1);
        for (int i = 0; i < 4; i++) send_tap(tv[i], 0);
        #2 rst = 1;
        in_valid = 1;
        in_data = 8'd5;
        #1;
        vecs++; if (kl_a1 !== 1'b0) begin errs++; $display("FAIL midrst_k_loaded: got %0d expected 0", kl_a1); end
        vecs++; if (ir_a1 !== 1'b0) begin errs++; $display("FAIL midrst_in_ready: got %0d expected 0", ir_a1); end
        vecs++; if (wr_a1 !== 1'b1) begin errs++; $display("FAIL midrst_w_ready: got %0d expected 1", wr_a1); end
        @(negedge clk);
        rst = 0;
        #1;
        vecs++; if (ir_a1 !== 1'b0) begin errs++; $display("FAIL midrst_refuse: got %0d expected 0", ir_a1); end
        @(negedge clk);
        in_valid = 0;
        vecs++; if (ov_a1 !== 1'b0) begin errs++; $display("FAIL midrst_no_valid: got %0d expected 0", ov_a1); end
        load_kernel(9);
        for (int i = 0; i < 9; i++) send_tap(tv[i], 0);
        vecs++; if (ov_a1 !== 1'b1) begin errs++; $display("FAIL midrst_redo_valid: got %0d expected 1", ov_a1); end
        vecs++; if (sum_a1 !== 8'd90) begin errs++; $display("FAIL midrst_redo_sum: got %0d expected 90", sum_a1); end
        @(negedge clk);
    endtask

    task automatic test_k1;
        grp = 1;
        wv[0] = 15;
        load_kernel(1);
        vecs++; if (kl_b !== 1'b1) begin errs++; $display("FAIL k1_k_loaded: got %0d expected 1", kl_b); end
        send_tap(8'd15, 0);
        vecs++; if (ov_b !== 1'b1) begin errs++; $display("FAIL k1_valid: got %0d expected 1", ov_b); end
        vecs++; if (sum_b !== 12'd225) begin errs++; $display("FAIL k1_sum: got %0d expected 225", sum_b); end
        vecs++; if (ovf_b !== 1'b0) begin errs++; $display("FAIL k1_ovf: got %0d expected 0", ovf_b); end
        @(negedge clk);
    endtask

    task automatic test_k5;
        grp = 2;
        for (int i = 0; i < 25; i++) begin
            wv[i] = 15;
            tv[i] = 15;
        end
        load_kernel(25);
        vecs++; if (kl_c1 !== 1'b1) begin errs++; $display("FAIL k5_k_loaded: got %0d expected 1", kl_c1); end
        for (int i = 0; i < 25; i++) send_tap(tv[i], 0);
        vecs++; if (ov_c1 !== 1'b1) begin errs++; $display("FAIL k5_valid: got %0d expected 1", ov_c1); end
        vecs++; if (sum_c1 !== 12'd4095) begin errs++; $display("FAIL k5_sum_sat: got %0d expected 4095", sum_c1); end
        vecs++; if (ovf_c1 !== 1'b1) begin errs++; $display("FAIL k5_ovf_sat: got %0d expected 1", ovf_c1); end
        vecs++; if (sum_c0 !== 12'd1529) begin errs++; $display("FAIL k5_sum_wrap: got %0d expected 1529", sum_c0); end
        vecs++; if (ovf_c0 !== 1'b1) begin errs++; $display("FAIL k5_ovf_wrap: got %0d expected 1", ovf_c0); end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_overflow;
        test_handshake;
        test_reset_mid;
        test_k1;
        test_k5;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
